// File: rtl/clk_switch_ctrl.sv
// Purpose: sequencer for the glitch-free 4:1 clock mux. It drives the mux select,
//          waits out the mux settle time, then pulses done or err.
// Latency: done/err is high 1 cycle after accept when nothing switches, and
//          SETTLE_CYC cycles after accept for a real switch.
// Backpressure: req_ready is low while a switch is in flight. req_valid is ignored
//          during that time, and the requester holds it until it is accepted.
//
// Ports:
//   clk, rst_n           always-on clock, synchronous active-low reset
//   req_valid/req_sel    switch request (valid/ready), req_ready back
//   clk_ok[3:0]          per-source clock-present flags, already synchronized to clk
//   mux_sel              select driven to clk_mux_4to1.sel
//   cur_sel              last committed source
//   busy                 switch in progress
//   done/err/failover    1-cycle completion / rejection-abort / auto-failover pulses
// Optional feature: define CLK_FAILOVER_EN to fail over automatically when the
//   current source stays dead in IDLE. Without it, failover is tied to 0.
module clk_switch_ctrl #(
    parameter int SETTLE_CYC = 16,
    parameter int CNT_W      = 5,
    parameter int RST_SEL    = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    input  logic [1:0] req_sel,
    output logic       req_ready,
    input  logic [3:0] clk_ok,
    output logic [1:0] mux_sel,
    output logic [1:0] cur_sel,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       failover
);

    typedef enum logic {IDLE, SWITCH} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             accept;

    assign accept = req_valid & req_ready;

`ifdef CLK_FAILOVER_EN
    logic       dead_q;   // clk_ok[cur_sel] was low on the previous IDLE cycle with no accept
    logic       fo_pend;  // the switch in flight was started by failover
    logic [1:0] fo_idx;
    logic       fo_any;

    // Find the lowest-index live source. The loop scans downward so the
    // lowest set bit is the last one written.
    always_comb begin
        fo_idx = 2'd0;
        fo_any = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (clk_ok[i]) begin
                fo_idx = 2'(i);
                fo_any = 1'b1;
            end
        end
    end
`else
    assign failover = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            mux_sel   <= 2'(RST_SEL);
            cur_sel   <= 2'(RST_SEL);
            req_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            cnt       <= '0;
`ifdef CLK_FAILOVER_EN
            failover  <= 1'b0;
            dead_q    <= 1'b0;
            fo_pend   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
`ifdef CLK_FAILOVER_EN
            failover <= 1'b0;
`endif
            case (state)
                IDLE: begin
`ifdef CLK_FAILOVER_EN
                    dead_q <= !accept && !clk_ok[cur_sel];
`endif
                    if (accept) begin
                        if (req_sel == cur_sel) begin
                            done <= 1'b1;
                        end else if (!clk_ok[req_sel]) begin
                            err <= 1'b1;
                        end else begin
                            mux_sel   <= req_sel;
                            cnt       <= CNT_W'(SETTLE_CYC - 1);
                            state     <= SWITCH;
                            req_ready <= 1'b0;
                            busy      <= 1'b1;
`ifdef CLK_FAILOVER_EN
                            fo_pend   <= 1'b0;
`endif
                        end
                    end
`ifdef CLK_FAILOVER_EN
                    // This is the second consecutive dead cycle. When no source
                    // is alive, nothing is loaded and dead_q stays set, so the
                    // check repeats every cycle.
                    else if (dead_q && !clk_ok[cur_sel] && fo_any) begin
                        mux_sel   <= fo_idx;
                        cnt       <= CNT_W'(SETTLE_CYC - 1);
                        state     <= SWITCH;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        fo_pend   <= 1'b1;
                    end
`endif
                end
                SWITCH: begin
`ifdef CLK_FAILOVER_EN
                    dead_q <= 1'b0;
`endif
                    // Only the target source is watched here. The old source
                    // may die freely, because the mux is already moving off it.
                    if (!clk_ok[mux_sel]) begin
                        mux_sel   <= cur_sel;
                        err       <= 1'b1;
                        state     <= IDLE;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                    end else if (cnt == '0) begin
                        cur_sel   <= mux_sel;
                        state     <= IDLE;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
`ifdef CLK_FAILOVER_EN
                        if (fo_pend) failover <= 1'b1;
                        else         done     <= 1'b1;
`else
                        done      <= 1'b1;
`endif
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// Purpose: self-checking directed bench for clk_switch_ctrl with default parameters.
// Latency: every input is driven and every output sampled 1 ns after posedge clk.
// Backpressure: the bench holds req_valid for one cycle, or longer where it
//               deliberately tests the busy case.
module tb_clk_switch_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic [1:0] req_sel;
    logic       req_ready;
    logic [3:0] clk_ok;
    logic [1:0] mux_sel;
    logic [1:0] cur_sel;
    logic       busy;
    logic       done;
    logic       err;
    logic       failover;

    int n_chk = 0;
    int n_err = 0;
    int seen;

    clk_switch_ctrl #(.SETTLE_CYC(16), .CNT_W(5), .RST_SEL(0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_sel   (req_sel),
        .req_ready (req_ready),
        .clk_ok    (clk_ok),
        .mux_sel   (mux_sel),
        .cur_sel   (cur_sel),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .failover  (failover)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a request that is accepted at the next edge. Sampling happens after that edge.
    task automatic request(input logic [1:0] sel);
        req_valid = 1'b1;
        req_sel   = sel;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic check_idle(input string tag, input logic [1:0] ms, input logic [1:0] cs);
        check({tag, ".mux_sel"}, 32'(mux_sel), 32'(ms));
        check({tag, ".cur_sel"}, 32'(cur_sel), 32'(cs));
        check({tag, ".req_ready"}, 32'(req_ready), 32'd1);
        check({tag, ".busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_sel = 2'd0; clk_ok = 4'hF;
        #1;
        tick(); tick();
        rst_n = 1'b1;

        // Reset state.
        check_idle("rst", 2'd0, 2'd0);
        check("rst.done", 32'(done), 32'd0);
        check("rst.err", 32'(err), 32'd0);
        check("rst.failover", 32'(failover), 32'd0);

        // Switch 0->2. The old source dies mid-switch, which must not matter.
        request(2'd2);
        check("sw2.mux_sel", 32'(mux_sel), 32'd2);
        check("sw2.busy", 32'(busy), 32'd1);
        check("sw2.req_ready", 32'(req_ready), 32'd0);
        seen = 0;
        for (int k = 1; k <= 15; k++) begin
            if (k == 6) clk_ok = 4'b1110;
            tick();
            if (done || !busy) seen++;
        end
        check("sw2.early_done", 32'(seen), 32'd0);
        tick();
        check("sw2.done", 32'(done), 32'd1);
        check("sw2.err", 32'(err), 32'd0);
        check_idle("sw2", 2'd2, 2'd2);
        clk_ok = 4'hF;
        tick();
        check("sw2.done_width", 32'(done), 32'd0);

        // Requesting the current source only pulses done.
        request(2'd2);
        check("same.done", 32'(done), 32'd1);
        check_idle("same", 2'd2, 2'd2);
        tick();
        check("same.done_width", 32'(done), 32'd0);

        // Return to source 0.
        request(2'd0);
        for (int k = 1; k <= 15; k++) tick();
        tick();
        check("back0.done", 32'(done), 32'd1);
        check_idle("back0", 2'd0, 2'd0);
        tick();

        // A request to a dead source is rejected.
        clk_ok = 4'b1011;
        request(2'd2);
        check("dead.err", 32'(err), 32'd1);
        check("dead.done", 32'(done), 32'd0);
        check_idle("dead", 2'd0, 2'd0);
        tick();
        check("dead.err_width", 32'(err), 32'd0);

        // Switch 0->3. A request held while busy is ignored. The target dies 5 cycles after accept.
        clk_ok = 4'hF;
        request(2'd3);
        check("ab.mux_sel", 32'(mux_sel), 32'd3);
        req_valid = 1'b1; req_sel = 2'd1;
        tick(); tick(); tick();
        check("ab.ignore_busy", 32'(mux_sel), 32'd3);
        req_valid = 1'b0;
        tick();
        clk_ok = 4'b0111;
        tick();
        check("ab.err", 32'(err), 32'd1);
        check("ab.done", 32'(done), 32'd0);
        check_idle("ab", 2'd0, 2'd0);
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (done || err) seen++;
        end
        check("ab.no_more_pulse", 32'(seen), 32'd0);

        // Reset mid-switch returns to reset values without a pulse.
        clk_ok = 4'hF;
        request(2'd1);
        for (int k = 0; k < 5; k++) tick();
        check("mid.busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        tick();
        check_idle("mid", 2'd0, 2'd0);
        check("mid.done", 32'(done), 32'd0);
        check("mid.err", 32'(err), 32'd0);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (done || err || busy) seen++;
        end
        check("mid.quiet", 32'(seen), 32'd0);

`ifdef CLK_FAILOVER_EN
        // Failover: cur_sel=1 dies. After 2 dead cycles it switches to source 0,
        // and the pulse appears 16 cycles after that.
        request(2'd1);
        for (int k = 0; k < 16; k++) tick();
        check("fo.cur1", 32'(cur_sel), 32'd1);
        tick();
        clk_ok = 4'b0101;
        tick(); tick();
        check("fo.mux_sel", 32'(mux_sel), 32'd0);
        check("fo.busy", 32'(busy), 32'd1);
        for (int k = 0; k < 16; k++) tick();
        check("fo.failover", 32'(failover), 32'd1);
        check("fo.done", 32'(done), 32'd0);
        check_idle("fo", 2'd0, 2'd0);
`else
        check("nofo.failover", 32'(failover), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
